mux_scan_ctrl: RTL and testbench

- Upstream sequencer for the 8:1 byte multiplexer (data[8], sel, y).
- Walks the mux select through a masked set of channels in ascending order and waits a programmable settle time after each select change.
- Captures the mux output and presents it downstream as channel/data words over a valid/ready handshake.
- Stalls the scan while the downstream consumer applies backpressure.

---
 rtl/mux_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 byte mux: steps sel over a masked channel set,
// waits out the settle time, then hands each sample downstream via valid/ready.
module mux_scan_ctrl #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int DATA_W = 8,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] y_in,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t              state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [3:0]          cnt_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   data_q;
    logic [SEL_W-1:0]    chan_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic                first_hit;
    logic [SEL_W-1:0]    first_idx;
    logic                next_hit;
    logic [SEL_W-1:0]    next_idx;

    // Descending walk so the lowest qualifying channel wins.
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_hit = 1'b1;
                first_idx = SEL_W'(i);
            end
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_hit = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (first_hit) begin
                            mask_q  <= chan_mask;
                            sel_q   <= first_idx;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_SETTLE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        data_q  <= y_in;
                        chan_q  <= sel_q;
                        valid_q <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (next_hit) begin
                            sel_q   <= next_idx;
                            cnt_q   <= '0;
                            state_q <= S_SETTLE;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 8:1 mux on y_in.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] chan_mask;
    logic [2:0] sel;
    logic [7:0] y_in;
    logic [7:0] out_data;
    logic [2:0] out_chan;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [7:0] din [8] = '{8'h00, 8'hA1, 8'hA2, 8'hA3,
                            8'hB4, 8'hB5, 8'hB6, 8'hB7};

    int passed = 0;
    int total  = 0;

    logic [2:0] exp_ch [8];
    int         exp_n;

    mux_scan_ctrl #(
        .NUM_CH(8), .SEL_W(3), .DATA_W(8), .SETTLE(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .chan_mask(chan_mask),
        .sel(sel), .y_in(y_in), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done)
    );

    assign y_in = din[sel];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // mode 0: plain, 1: backpressure at channel 3, 2: restart/mask noise
    task automatic run_scan(input logic [7:0] mask, input int mode);
        chan_mask = mask;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_sel", sel, exp_ch[0]);
        chk("start_valid", out_valid, 0);
        for (int i = 0; i < exp_n; i++) begin
            step();
            chk("w_valid", out_valid, 1);
            chk("w_chan", out_chan, exp_ch[i]);
            chk("w_data", out_data, din[exp_ch[i]]);
            chk("w_sel", sel, exp_ch[i]);
            if (mode == 1 && exp_ch[i] == 3'd3) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk("bp_valid", out_valid, 1);
                    chk("bp_data", out_data, 8'hA3);
                    chk("bp_sel", sel, 3);
                end
                out_ready = 1'b1;
            end
            if (mode == 2 && i == 3) begin
                start     = 1'b1;
                chan_mask = 8'h01;
            end
            step();
            start = 1'b0;
            chk("h_valid", out_valid, 0);
            if (i < exp_n - 1) begin
                chk("h_sel", sel, exp_ch[i+1]);
                chk("h_busy", busy, 1);
                chk("h_done", done, 0);
            end else begin
                chk("end_done", done, 1);
                chk("end_busy", busy, 0);
                chk("end_sel", sel, exp_ch[i]);
            end
        end
        step();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_valid", out_valid, 0);
    endtask

    task automatic set_full();
        exp_n = 8;
        for (int i = 0; i < 8; i++) exp_ch[i] = 3'(i);
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        start     = 1'b0;
        chan_mask = 8'h00;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_sel", sel, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_chan", out_chan, 0);
        reset = 1'b0;
        step();

        set_full();
        run_scan(8'hFF, 0);

        exp_n     = 3;
        exp_ch[0] = 3'd0;
        exp_ch[1] = 3'd2;
        exp_ch[2] = 3'd7;
        run_scan(8'b1000_0101, 0);

        set_full();
        run_scan(8'hFF, 1);

        chan_mask = 8'h00;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("zm_done", done, 1);
        chk("zm_busy", busy, 0);
        chk("zm_valid", out_valid, 0);
        step();
        chk("zm_done_off", done, 0);
        chk("zm_valid2", out_valid, 0);
        chk("zm_busy2", busy, 0);

        chan_mask = 8'hFF;
        start     = 1'b1;
        step();
        start     = 1'b0;
        seen      = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (out_valid && out_chan == 3'd4) seen = 1'b1;
        end
        chk("ra_reach4", {31'd0, seen}, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ra_sel", sel, 0);
        chk("ra_valid", out_valid, 0);
        chk("ra_busy", busy, 0);
        chk("ra_done", done, 0);
        step();
        chk("ra_done2", done, 0);

        set_full();
        run_scan(8'hFF, 0);

        set_full();
        run_scan(8'hFF, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
